// File: rtl/riscv_ctrl_pkg.sv
// Shared constants for the multi-cycle RISC-V control slice.
// Holds the supported opcode encodings, the ALU operation codes driven on
// Operation, and the sequencer state encoding (also exported on the debug
// "state" port, so the numeric values are fixed).
package riscv_ctrl_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SLL = 4'b0011;
   localparam logic [3:0] ALU_SUB = 4'b0110;

   typedef enum logic [2:0] {
      ST_INIT   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5
   } state_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Shared memory port between the sequencer and the unified memory.
// Signals:
//   mem_ready - memory completes the current request this cycle
//   IorD      - 0 = instruction address (PC), 1 = data address (ALUOut)
//   MemRead   - read request
//   MemWrite  - write request
// master: the control sequencer; slave: the memory.
interface multicycle_control_if;

   logic mem_ready;
   logic IorD;
   logic MemRead;
   logic MemWrite;

   modport master (
      input  mem_ready,
      output IorD,
      output MemRead,
      output MemWrite
   );

   modport slave (
      output mem_ready,
      input  IorD,
      input  MemRead,
      input  MemWrite
   );

endinterface

// File: rtl/multicycle_alu_decode.sv
// Combinational ALU decode for the multi-cycle control.
// Ports:
//   opcode_i     - instruction bits [6:0]
//   funct_i      - {instr[30], instr[14:12]}
//   operation_o  - ALU operation code for this instruction
//   illegalEnc_o - opcode or funct combination is not supported
module multicycle_alu_decode
   import riscv_ctrl_pkg::*;
(
   input  logic [6:0] opcode_i,
   input  logic [3:0] funct_i,
   output logic [3:0] operation_o,
   output logic       illegalEnc_o
);

   // Map each supported opcode/funct pair to an ALU code. I-type ignores
   // instr[30] because immediates reuse that bit. Anything not listed is
   // flagged so the sequencer can drop the instruction in DECODE.
   always_comb begin
      operation_o  = ALU_ADD;
      illegalEnc_o = 1'b0;
      case (opcode_i)
         OP_R: begin
            case (funct_i)
               4'b0000: operation_o = ALU_ADD;
               4'b1000: operation_o = ALU_SUB;
               4'b0111: operation_o = ALU_AND;
               4'b0110: operation_o = ALU_OR;
               default: illegalEnc_o = 1'b1;
            endcase
         end
         OP_I: begin
            case (funct_i[2:0])
               3'b000:  operation_o = ALU_ADD;
               3'b111:  operation_o = ALU_AND;
               3'b110:  operation_o = ALU_OR;
               3'b001:  operation_o = ALU_SLL;
               default: illegalEnc_o = 1'b1;
            endcase
         end
         OP_LOAD, OP_STORE: operation_o = ALU_ADD;
         OP_BRANCH:         operation_o = ALU_SUB;
         default:           illegalEnc_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control sequencer: steps each instruction through
// FETCH, DECODE, EXEC, MEM and WB over one shared memory port.
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   Opcode, Funct, Zero - instruction fields from the IR, ALU zero flag
//   bus                 - shared memory port (mem_ready in; IorD/MemRead/MemWrite out)
//   IRWrite, PCWrite, PCSrc, Branch, MemtoReg, ALUSrc, RegWrite, Operation
//                       - datapath controls
//   illegal             - one-cycle pulse on an unsupported encoding
//   state               - current sequencer state, for debug
//   instret             - retired-instruction count, wraps modulo 2^CNT_W
module multicycle_control
   import riscv_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [6:0]           Opcode,
   input  logic [3:0]           Funct,
   input  logic                 Zero,
   multicycle_control_if.master bus,
   output logic                 IRWrite,
   output logic                 PCWrite,
   output logic                 PCSrc,
   output logic                 Branch,
   output logic                 MemtoReg,
   output logic                 ALUSrc,
   output logic [3:0]           Operation,
   output logic                 RegWrite,
   output logic                 illegal,
   output logic [2:0]           state,
   output logic [CNT_W-1:0]     instret
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] instret_q;
   logic             retire;
   logic             iorD, memRead, memWrite;
   logic [3:0]       aluOp;
   logic             illegalEnc;
   logic             isLoad, isStore, isBranch, isImm;

   multicycle_alu_decode u_aluDecode (
      .opcode_i     (Opcode),
      .funct_i      (Funct),
      .operation_o  (aluOp),
      .illegalEnc_o (illegalEnc)
   );

   assign isLoad   = (Opcode == OP_LOAD);
   assign isStore  = (Opcode == OP_STORE);
   assign isBranch = (Opcode == OP_BRANCH);
   assign isImm    = (Opcode == OP_I);

   // State register. Reset parks the sequencer in INIT, which also forces
   // every decoded output low without waiting for a clock edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_INIT;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and output decode. The IR is stable from DECODE onward, so
   // later states re-decode Opcode directly instead of latching a class.
   // Memory requests are held as plain Moore outputs so they stay stable
   // through every wait cycle; only the FETCH write strobes and the branch
   // PCWrite look at inputs.
   always_comb begin
      state_d   = state_q;
      iorD      = 1'b0;
      memRead   = 1'b0;
      memWrite  = 1'b0;
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      PCSrc     = 1'b0;
      Branch    = 1'b0;
      MemtoReg  = 1'b0;
      ALUSrc    = 1'b0;
      Operation = ALU_AND;
      RegWrite  = 1'b0;
      illegal   = 1'b0;
      retire    = 1'b0;
      case (state_q)
         ST_INIT: state_d = ST_FETCH;
         ST_FETCH: begin
            memRead = 1'b1;
            if (bus.mem_ready) begin
               IRWrite = 1'b1;
               PCWrite = 1'b1;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (illegalEnc) begin
               illegal = 1'b1;
               state_d = ST_FETCH;
            end else begin
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            Operation = aluOp;
            ALUSrc    = isImm | isLoad | isStore;
            if (isBranch) begin
               Branch  = 1'b1;
               PCSrc   = 1'b1;
               PCWrite = Zero;
               retire  = 1'b1;
               state_d = ST_FETCH;
            end else if (isLoad || isStore) begin
               state_d = ST_MEM;
            end else begin
               state_d = ST_WB;
            end
         end
         ST_MEM: begin
            iorD     = 1'b1;
            memRead  = isLoad;
            memWrite = isStore;
            if (bus.mem_ready) begin
               if (isLoad) begin
                  state_d = ST_WB;
               end else begin
                  retire  = 1'b1;
                  state_d = ST_FETCH;
               end
            end
         end
         ST_WB: begin
            RegWrite = 1'b1;
            MemtoReg = isLoad;
            retire   = 1'b1;
            state_d  = ST_FETCH;
         end
         default: state_d = ST_INIT;
      endcase
   end

   // Retired-instruction counter; bumps on the edge that leaves the
   // retiring state and wraps naturally at its width.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instret_q <= '0;
      end else if (retire) begin
         instret_q <= instret_q + CNT_W'(1);
      end
   end

   assign bus.IorD     = iorD;
   assign bus.MemRead  = memRead;
   assign bus.MemWrite = memWrite;
   assign state        = state_q;
   assign instret      = instret_q;

endmodule
